// File: rtl/board_write_arbiter.sv
// Board RAM write-port arbiter: two engines share one port, writes gated to a VS-triggered window.
// Optional COLLISION_DETECT_EN adds a sticky same-address collision flag (oCOLLISION).
module board_write_arbiter #(
  parameter int unsigned ADDR_W        = 11,
  parameter int unsigned DATA_W        = 2,
  parameter int unsigned WINDOW_CYCLES = 4000
) (
  input  logic              iVGA_CLK,
  input  logic              iRST_n,
  input  logic              iVS,
  input  logic              iREQ0,
  input  logic              iREQ1,
  input  logic [ADDR_W-1:0] iADDR0,
  input  logic [ADDR_W-1:0] iADDR1,
  input  logic [DATA_W-1:0] iDATA0,
  input  logic [DATA_W-1:0] iDATA1,
  output logic              oGNT0,
  output logic              oGNT1,
  output logic              oWE,
  output logic [ADDR_W-1:0] oWADDR,
  output logic [DATA_W-1:0] oWDATA,
  output logic              oWINDOW,
  output logic              oFRAME_TICK
`ifdef COLLISION_DETECT_EN
  ,
  output logic              oCOLLISION
`endif
);

  localparam int unsigned CntW = $clog2(WINDOW_CYCLES + 1);

  typedef enum logic [0:0] {StWaitVs, StOpen} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              vs_q;
  logic              tick_q, tick_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              rr_q, rr_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              vs_fall, arb_en, elig0, elig1;

  assign vs_fall = vs_q & ~iVS;
  assign arb_en  = (state_q == StOpen) && (cnt_q != '0);
  // An engine is not eligible in its own grant cycle; that enforces 1 write per 2 cycles each.
  assign elig0   = iREQ0 & ~gnt0_q;
  assign elig1   = iREQ1 & ~gnt1_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    gnt0_d  = 1'b0;
    gnt1_d  = 1'b0;
    rr_d    = rr_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;

    unique case (state_q)
      StWaitVs: begin
        if (vs_fall) begin
          state_d = StOpen;
          cnt_d   = CntW'(WINDOW_CYCLES - 1);
          tick_d  = 1'b1;
        end
      end
      StOpen: begin
        if (cnt_q == '0) begin
          state_d = StWaitVs;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      default: state_d = StWaitVs;
    endcase

    // rr_q holds the engine granted last; on a tie the other one wins.
    if (arb_en) begin
      if (elig0 && (!elig1 || rr_q)) begin
        gnt0_d = 1'b1;
      end else if (elig1) begin
        gnt1_d = 1'b1;
      end
    end

    if (gnt0_d) begin
      rr_d    = 1'b0;
      waddr_d = iADDR0;
      wdata_d = iDATA0;
    end else if (gnt1_d) begin
      rr_d    = 1'b1;
      waddr_d = iADDR1;
      wdata_d = iDATA1;
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q <= StWaitVs;
      cnt_q   <= '0;
      vs_q    <= 1'b0;
      tick_q  <= 1'b0;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      rr_q    <= 1'b1;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vs_q    <= iVS;
      tick_q  <= tick_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      rr_q    <= rr_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign oGNT0       = gnt0_q;
  assign oGNT1       = gnt1_q;
  assign oWE         = gnt0_q | gnt1_q;
  assign oWADDR      = waddr_q;
  assign oWDATA      = wdata_q;
  assign oWINDOW     = (state_q == StOpen);
  assign oFRAME_TICK = tick_q;

`ifdef COLLISION_DETECT_EN
  logic [3:0][ADDR_W-1:0] list0_q, list1_q;
  logic [2:0]             n0_q, n1_q;
  logic                   coll_q;
  logic                   hit0, hit1;

  // hit0: engine 0's current address is in engine 1's list, and vice versa.
  always_comb begin
    hit0 = 1'b0;
    hit1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if ((i < int'(n1_q)) && (list1_q[i] == iADDR0)) hit0 = 1'b1;
      if ((i < int'(n0_q)) && (list0_q[i] == iADDR1)) hit1 = 1'b1;
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      list0_q <= '0;
      list1_q <= '0;
      n0_q    <= '0;
      n1_q    <= '0;
      coll_q  <= 1'b0;
    end else if (tick_d) begin
      n0_q   <= '0;
      n1_q   <= '0;
      coll_q <= 1'b0;
    end else begin
      if (gnt0_d) begin
        if (hit0) coll_q <= 1'b1;
        if (n0_q != 3'd4) begin
          list0_q[n0_q[1:0]] <= iADDR0;
          n0_q               <= n0_q + 3'd1;
        end
      end
      if (gnt1_d) begin
        if (hit1) coll_q <= 1'b1;
        if (n1_q != 3'd4) begin
          list1_q[n1_q[1:0]] <= iADDR1;
          n1_q               <= n1_q + 3'd1;
        end
      end
    end
  end

  assign oCOLLISION = coll_q;
`endif

endmodule
